// File: rtl/seg7_scan_capture.sv
// Captures a three-digit multiplexed 7-segment scan into hex nibbles, with stability filtering.
// Optional SEG7_CAP_BIN_EN adds a registered binary value of the frame and a BCD-valid flag.
module seg7_scan_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] dig_sel,
  input  logic [6:0] seg,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       frame_valid,
  output logic       pat_err
`ifdef SEG7_CAP_BIN_EN
  ,
  output logic [9:0] value,
  output logic       bcd_ok
`endif
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [2:0] sel);
    return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
  endfunction

  // Returns {valid, nibble}; valid is low for patterns outside the hex table.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= STABLE_MAX) ? STABLE_MAX : c + 8'd1;
  endfunction

  logic [9:0]      samp_p0_q, samp_p0_d;
  logic [9:0]      samp_p1_q, samp_p1_d;
  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [9:0]      stored_q, stored_d;
  logic [2:0][3:0] digit_q, digit_d;
  logic [2:0]      captured_q, captured_d;
  logic            frame_valid_q, frame_valid_d;
  logic            pat_err_q, pat_err_d;

  logic [2:0] cur_sel;
  logic [6:0] cur_seg;
  logic       same;
  logic [7:0] cnt_inc;
  logic [4:0] dec;
  logic [7:0] reload_cnt;

  assign cur_sel    = samp_p1_q[9:7];
  assign cur_seg    = samp_p1_q[6:0];
  assign same       = (samp_p1_q == stored_q);
  assign cnt_inc    = sat_inc(cnt_q);
  assign dec        = seg_decode(cur_seg);
  // Blanking (000) never counts toward a bad-strobe error.
  assign reload_cnt = (cur_sel == 3'b000) ? 8'd0 : 8'd1;

  // Stage p0/p1: two-flop input synchronizer
  always_comb begin
    samp_p0_d = {dig_sel, seg};
    samp_p1_d = samp_p0_q;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stored_d      = stored_q;
    digit_d       = digit_q;
    pat_err_d     = pat_err_q;
    frame_valid_d = &captured_q;
    captured_d    = (&captured_q) ? 3'b000 : captured_q;

    case (state_q)
      IDLE: begin
        if (is_onehot(cur_sel)) begin
          state_d  = SETTLE;
          stored_d = samp_p1_q;
          cnt_d    = 8'd1;
        end else if ((cur_sel != 3'b000) && same) begin
          cnt_d = cnt_inc;
          if (cnt_inc == STABLE_MAX) pat_err_d = 1'b1;
        end else begin
          stored_d = samp_p1_q;
          cnt_d    = reload_cnt;
        end
      end
      SETTLE, HOLD: begin
        if (same) begin
          if (state_q == SETTLE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == STABLE_MAX) begin
              state_d = HOLD;
              if (dec[4]) begin
                if (cur_sel[2]) digit_d[0] = dec[3:0];
                if (cur_sel[1]) digit_d[1] = dec[3:0];
                if (cur_sel[0]) digit_d[2] = dec[3:0];
                captured_d = captured_d | {cur_sel[0], cur_sel[1], cur_sel[2]};
              end else begin
                pat_err_d = 1'b1;
              end
            end
          end
        end else if (is_onehot(cur_sel)) begin
          state_d  = SETTLE;
          stored_d = samp_p1_q;
          cnt_d    = 8'd1;
        end else begin
          state_d  = IDLE;
          stored_d = samp_p1_q;
          cnt_d    = reload_cnt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_p0_q     <= '0;
      samp_p1_q     <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      stored_q      <= '0;
      digit_q       <= '0;
      captured_q    <= '0;
      frame_valid_q <= 1'b0;
      pat_err_q     <= 1'b0;
    end else begin
      samp_p0_q     <= samp_p0_d;
      samp_p1_q     <= samp_p1_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stored_q      <= stored_d;
      digit_q       <= digit_d;
      captured_q    <= captured_d;
      frame_valid_q <= frame_valid_d;
      pat_err_q     <= pat_err_d;
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign frame_valid = frame_valid_q;
  assign pat_err     = pat_err_q;

`ifdef SEG7_CAP_BIN_EN
  logic [9:0] value_q, value_d;
  logic       bcd_ok_q, bcd_ok_d;
  logic       all_dec;
  logic [9:0] bin_sum;

  assign all_dec = (digit_q[0] <= 4'd9) && (digit_q[1] <= 4'd9) && (digit_q[2] <= 4'd9);
  assign bin_sum = ({6'd0, digit_q[2]} * 10'd100) + ({6'd0, digit_q[1]} * 10'd10)
                 + {6'd0, digit_q[0]};

  // Latched on the same edge that raises frame_valid, from the completed frame's digits.
  always_comb begin
    value_d  = value_q;
    bcd_ok_d = bcd_ok_q;
    if (&captured_q) begin
      bcd_ok_d = all_dec;
      value_d  = all_dec ? bin_sum : 10'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      bcd_ok_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      bcd_ok_q <= bcd_ok_d;
    end
  end

  assign value  = value_q;
  assign bcd_ok = bcd_ok_q;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomized and directed bench for seg7_scan_capture against a run-length reference model.
// Also exercises the SEG7_CAP_BIN_EN outputs when that macro is defined.
module tb_seg7_scan_capture;

  localparam int STABLE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dig_sel;
  logic [6:0] seg;
  logic [3:0] digit0, digit1, digit2;
  logic       frame_valid, pat_err;
`ifdef SEG7_CAP_BIN_EN
  logic [9:0] value;
  logic       bcd_ok;
`endif

  seg7_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .dig_sel(dig_sel), .seg(seg),
    .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .frame_valid(frame_valid), .pat_err(pat_err)
`ifdef SEG7_CAP_BIN_EN
    , .value(value), .bcd_ok(bcd_ok)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_count = 0;
  int seen6    = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [9:0] m_s1, m_s2, m_prev;
  int         m_run;
  int         m_dig [3];
  bit         m_flag [3];
  bit         m_fv, m_perr, m_bcd;
  int         m_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 0;
    for (int i = 0; i < 3; i++) begin m_dig[i] = 0; m_flag[i] = 0; end
    m_fv = 0; m_perr = 0; m_bcd = 0; m_val = 0;
  endtask

  task automatic model_step(input logic r, input logic [9:0] in_v);
    logic [9:0] s;
    logic [2:0] sel;
    int idx, code;
    if (r) begin
      model_reset();
      return;
    end
    s = m_s2; m_s2 = m_s1; m_s1 = in_v;
    m_fv = m_flag[0] && m_flag[1] && m_flag[2];
    if (m_fv) begin
      m_bcd = (m_dig[0] <= 9) && (m_dig[1] <= 9) && (m_dig[2] <= 9);
      m_val = m_bcd ? m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0] : 0;
      for (int i = 0; i < 3; i++) m_flag[i] = 0;
    end
    if (s == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = s;
    if (m_run == STABLE) begin
      sel = s[9:7];
      if ($countones(sel) == 1) begin
        idx  = sel[2] ? 0 : (sel[1] ? 1 : 2);
        code = -1;
        for (int k = 0; k < 16; k++) if (hex_tab[k] == s[6:0]) code = k;
        if (code >= 0) begin
          m_dig[idx]  = code;
          m_flag[idx] = 1;
        end else begin
          m_perr = 1;
        end
      end else if (sel != 3'b000) begin
        m_perr = 1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [2:0] s, input logic [6:0] g);
    rst = r; dig_sel = s; seg = g;
    @(posedge clk);
    model_step(r, {s, g});
    #1;
    check_eq("digit0", digit0, m_dig[0]);
    check_eq("digit1", digit1, m_dig[1]);
    check_eq("digit2", digit2, m_dig[2]);
    check_eq("frame_valid", frame_valid, m_fv);
    check_eq("pat_err", pat_err, m_perr);
`ifdef SEG7_CAP_BIN_EN
    check_eq("value", value, m_val);
    check_eq("bcd_ok", bcd_ok, m_bcd);
`endif
    if (frame_valid) fv_count++;
    if (digit0 == 4'h6) seen6++;
  endtask

  task automatic hold(input logic [2:0] s, input logic [6:0] g, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, s, g);
  endtask

  task automatic do_reset();
    cycle(1'b1, 3'b000, 7'h00);
    cycle(1'b1, 3'b000, 7'h00);
  endtask

  task automatic scan3(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
    hold(3'b100, u, 20);
    hold(3'b010, t, 20);
    hold(3'b001, h, 20);
    hold(3'b000, 7'h00, 5);
  endtask

  initial begin
    logic [3:0] d1_save;
    logic [2:0] rs;
    logic [6:0] rg;
    int         pick;
    model_reset();
    do_reset();
    check_eq("rst_digit0", digit0, 0);
    check_eq("rst_pat_err", pat_err, 0);
    check_eq("rst_frame_valid", frame_valid, 0);

    // Basic scan 1,2,3
    fv_count = 0;
    scan3(7'h06, 7'h5B, 7'h4F);
    check_eq("scan_d0", digit0, 1);
    check_eq("scan_d1", digit1, 2);
    check_eq("scan_d2", digit2, 3);
    check_eq("scan_pulses", fv_count, 1);
`ifdef SEG7_CAP_BIN_EN
    check_eq("scan_value", value, 321);
    check_eq("scan_bcd_ok", bcd_ok, 1);
`endif

    // Short glitch of 6 must never be accepted
    seen6 = 0;
    hold(3'b100, 7'h7D, 15);
    hold(3'b100, 7'h7F, 20);
    hold(3'b000, 7'h00, 4);
    check_eq("glitch_d0", digit0, 8);
    check_eq("glitch_seen6", seen6, 0);
    check_eq("glitch_pat_err", pat_err, 0);

    // Undecodable pattern
    d1_save  = digit1;
    fv_count = 0;
    hold(3'b010, 7'h01, 20);
    hold(3'b000, 7'h00, 4);
    check_eq("badseg_d1", digit1, d1_save);
    check_eq("badseg_pat_err", pat_err, 1);
    check_eq("badseg_pulses", fv_count, 0);

    // Non-one-hot strobe vs blanking
    do_reset();
    hold(3'b011, 7'h3F, 20);
    check_eq("badsel_pat_err", pat_err, 1);
    check_eq("badsel_d2", digit2, 0);
    do_reset();
    hold(3'b000, 7'h3F, 20);
    check_eq("blank_pat_err", pat_err, 0);

    // Reset in the middle of the third digit's settle
    do_reset();
    fv_count = 0;
    hold(3'b100, 7'h06, 20);
    hold(3'b010, 7'h5B, 20);
    hold(3'b001, 7'h4F, 8);
    cycle(1'b1, 3'b001, 7'h4F);
    hold(3'b000, 7'h00, 3);
    check_eq("midrst_pulses_pre", fv_count, 0);
    check_eq("midrst_d0", digit0, 0);
    scan3(7'h66, 7'h6D, 7'h07);
    check_eq("midrst_pulses_post", fv_count, 1);

    // Non-decimal frame
    fv_count = 0;
    scan3(7'h77, 7'h7C, 7'h39);
    check_eq("hex_d0", digit0, 4'hA);
    check_eq("hex_d1", digit1, 4'hB);
    check_eq("hex_d2", digit2, 4'hC);
    check_eq("hex_pulses", fv_count, 1);
`ifdef SEG7_CAP_BIN_EN
    check_eq("hex_bcd_ok", bcd_ok, 0);
    check_eq("hex_value", value, 0);
`endif

    // Randomized scan with occasional blanking, bad patterns and bad strobes
    do_reset();
    for (int n = 0; n < 120; n++) begin
      pick = $urandom_range(0, 19);
      case ($urandom_range(0, 2))
        0: rs = 3'b100;
        1: rs = 3'b010;
        default: rs = 3'b001;
      endcase
      if (pick == 0) rs = 3'b000;
      else if (pick == 1) rs = 3'($urandom_range(0, 7));
      rg = hex_tab[$urandom_range(0, 15)];
      if (pick == 2) rg = 7'($urandom_range(0, 127));
      hold(rs, rg, $urandom_range(1, 24));
    end
    hold(3'b000, 7'h00, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
